// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared types and constants for the iterative divider
package iter_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  localparam logic [4:0] ALU_UDIV = 5'b01110;
  localparam logic [4:0] ALU_SDIV = 5'b01111;

  // Lets the execute stage derive start from its ALU control field.
  function automatic logic is_div_op(input logic [4:0] alu_control);
    return (alu_control == ALU_UDIV) || (alu_control == ALU_SDIV);
  endfunction
endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/result bundle between execute stage and divider
interface iter_divider_if #(
  parameter int WIDTH = iter_divider_pkg::DIV_WIDTH
) ();
  logic             start;
  logic             op_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, op_signed, dividend, divisor, flush,
    input  stall, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, op_signed, dividend, divisor, flush,
    output stall, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider_div_step.sv
// rtl/iter_divider_div_step.sv - one restoring shift/trial-subtract step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvs holds between steps, so bit WIDTH of trial is a clean borrow flag.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider for UDIV/SDIV with flush and stall
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           reset,
  iter_divider_if.slave bus
);
  localparam int            CW    = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic             accept;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign dd_mag = (bus.op_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dv_mag = (bus.op_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // Gated by reset so the pipeline is never held while the unit is in reset.
  assign bus.stall = reset && (accept || (state == RUN));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_r),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      count           <= '0;
      rem_r           <= '0;
      quo_r           <= '0;
      dvs_r           <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (accept) begin
            bus.busy <= 1'b1;
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.quotient    <= '0;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              state <= RUN;
              count <= STEPS;
              rem_r <= '0;
              quo_r <= dd_mag;
              dvs_r <= dv_mag;
              q_neg <= bus.op_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_neg <= bus.op_signed && bus.dividend[WIDTH-1];
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            rem_r <= rem_step;
            quo_r <= quo_step;
            count <= count - CW'(1);
            // The final step and the sign fixup share one edge.
            if (count == CW'(1)) begin
              state           <= DONE;
              bus.quotient    <= q_neg ? -quo_step : quo_step;
              bus.remainder   <= r_neg ? -rem_step : rem_step;
              bus.div_by_zero <= 1'b0;
              bus.done        <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  issue request from execute stage (ALUControlE is UDIV or SDIV and the instruction is valid).
REQ-005 op_signed  input  1  1 = SDIV, 0 = UDIV; sampled with start.
REQ-006 dividend  input  WIDTH  numerator; sampled with start.
REQ-007 divisor  input  WIDTH  denominator; sampled with start.
REQ-008 flush  input  1  abort the operation in flight (driven from FlushE).
REQ-009 stall  output  1  hold fetch/decode/execute while the divide is pending.
REQ-010 busy  output  1  unit is not in IDLE.
REQ-011 done  output  1  single-cycle pulse; results valid.
REQ-012 quotient  output  WIDTH  result quotient.
REQ-013 remainder  output  WIDTH  result remainder.
REQ-014 div_by_zero  output  1  the last accepted operation had divisor == 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 with flush=0 SHALL accept the request: latch op_signed and the operand magnitudes (two's-complement absolute value when op_signed=1), and latch the result signs.
REQ-017 On acceptance with divisor != 0, the next state SHALL be RUN and the step counter SHALL load WIDTH.
REQ-018 On acceptance with divisor == 0, the next state SHALL be DONE, with quotient=0, remainder=dividend (unmodified) and div_by_zero=1.
REQ-019 Each RUN cycle SHALL perform one restoring step: shift {rem,quo} left by 1, then trial-subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient LSB to 1.
REQ-020 After WIDTH steps (counter reaches 0), the next state SHALL be DONE, with sign fixup applied on that transition.
REQ-021 Sign fixup: the quotient is negated when the dividend and divisor signs differ; the remainder takes the sign of the dividend; both are unsigned for UDIV.
REQ-022 Signed INT_MIN / -1 SHALL yield quotient=INT_MIN and remainder=0, with no flag raised.
REQ-023 Latency SHALL be WIDTH+1 rising edges from the accepting edge to the edge that enters DONE; the divide-by-zero case SHALL take 1 edge.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next acceptance.
REQ-026 stall = (IDLE & start & ~flush) | RUN; stall SHALL be low in DONE, so the dependent instruction advances with the result.
REQ-027 busy = (state != IDLE).
REQ-028 start while busy SHALL be ignored (no re-latch, no effect on the operation in progress).
REQ-029 flush in RUN or DONE SHALL return the FSM to IDLE on the next edge: no done pulse, and the outputs keep their previous values.
REQ-030 start and flush together in IDLE SHALL be ignored; flush has priority.

Reset
REQ-031 Asserting reset SHALL immediately force the state to IDLE and the step counter to 0.
REQ-032 Asserting reset SHALL immediately force quotient, remainder, div_by_zero, stall, busy and done to 0.
REQ-033 Reset during RUN SHALL discard the operation; after release, the unit accepts start on the first edge.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the WIDTH default, and the ALU control codes UDIV=5'b01110 and SDIV=5'b01111, so the execute stage can derive start.
REQ-035 One combinational sub-module, div_step, SHALL implement the single shift/trial-subtract step; iter_divider instantiates it once.
REQ-036 The step counter SHALL be $clog2(WIDTH)+1 bits wide.
REQ-037 No latches and no combinational path from dividend or divisor to any output.

Verification
REQ-038 Unsigned: start with 100 / 7 -> done exactly 33 edges after acceptance, quotient=14, remainder=2, div_by_zero=0, stall high for 33 cycles.
REQ-039 Signed: -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
REQ-040 Divide by zero: 55 / 0 (unsigned) -> done 1 edge after acceptance, quotient=0, remainder=55, div_by_zero=1.
REQ-041 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-042 Flush at RUN cycle 10 -> IDLE next edge, no done pulse, outputs unchanged; then a new start with 9 / 3 -> quotient=3, remainder=0.
REQ-043 Reset low at RUN cycle 5 -> all outputs 0 immediately; after release, start accepted on the first edge and completes normally.
